br_update_unit: RTL and testbench

- Update/recovery side of the branch predictor: the writer for the predictor's read path.
- Holds a FIFO of in-flight predictions, each with PC, predicted direction, predicted target and GHR snapshot.
- Matches in-order resolutions from execute against the oldest entry and drives PHT/PAs/BTB update strobes.
- On a mispredict, repairs the GHR, flushes wrong-path entries and stalls new predictions for a recovery window.

---
 rtl/br_update_unit_pkg.sv | 19 +
 rtl/br_update_unit_if.sv | 57 +++++
 rtl/br_update_unit_upd_fifo.sv | 63 ++++++
 rtl/br_update_unit.sv | 148 ++++++++++++++
 tb/tb_br_update_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/br_update_unit_pkg.sv
// Shared definitions for the branch-predictor update/recovery unit.
// This file holds the address and history widths, the update FSM state
// encodings and the packing width of an in-flight prediction record.
package br_update_unit_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int GHR_WIDTH  = 14;

    typedef enum logic {
        UPD_NORMAL  = 1'b0,
        UPD_RECOVER = 1'b1
    } upd_state_e;

    // A record is packed as {pred_torn, pc, target, ghr_snapshot}.
    function automatic int rec_width(input int addr_w, input int ghr_w);
        return 1 + 2 * addr_w + ghr_w;
    endfunction

endpackage

// File: rtl/br_update_unit_if.sv
// Bus between the predictor/execute side and the update unit.
// The predictor pushes records, execute resolves them, and the unit drives
// the update strobes back into the predictor tables.
interface br_update_unit_if
    import br_update_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int GHR_W  = GHR_WIDTH,
    parameter int DEPTH  = 8
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    // Prediction push channel
    logic              pred_valid;
    logic              pred_ready;
    logic [ADDR_W-1:0] pred_pc;
    logic              pred_torn;
    logic [ADDR_W-1:0] pred_tar;
    logic [GHR_W-1:0]  pred_ghr;

    // In-order resolution from execute
    logic              res_valid;
    logic              res_cond;
    logic              res_torn;
    logic [ADDR_W-1:0] res_tar;

    // Update / recovery outputs
    logic              gshare_wr_en;
    logic              gshare_wr_data;
    logic              PAs_up_en;
    logic              PAs_torn;
    logic              btb_up_en;
    logic [ADDR_W-1:0] up_pc;
    logic [ADDR_W-1:0] up_addr;
    logic              gshare_reen;
    logic [GHR_W-1:0]  re_GHR;
    logic              flush;
    logic [OCC_W-1:0]  occupancy;
    logic              res_err;

    modport master (
        output pred_valid, pred_pc, pred_torn, pred_tar, pred_ghr,
        output res_valid, res_cond, res_torn, res_tar,
        input  pred_ready,
        input  gshare_wr_en, gshare_wr_data, PAs_up_en, PAs_torn, btb_up_en,
        input  up_pc, up_addr, gshare_reen, re_GHR, flush, occupancy, res_err
    );

    modport slave (
        input  pred_valid, pred_pc, pred_torn, pred_tar, pred_ghr,
        input  res_valid, res_cond, res_torn, res_tar,
        output pred_ready,
        output gshare_wr_en, gshare_wr_data, PAs_up_en, PAs_torn, btb_up_en,
        output up_pc, up_addr, gshare_reen, re_GHR, flush, occupancy, res_err
    );

endinterface

// File: rtl/br_update_unit_upd_fifo.sv
// Synchronous FIFO of packed in-flight prediction records.
// clr empties it in one cycle and wins over push/pop. The caller guarantees
// push only when not full (or together with a pop) and pop only when not empty.
module br_update_unit_upd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [OCC_W-1:0] occupancy
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] count_q;

    // Record storage write.
    // NOTE: the storage array is deliberately not reset; the pointers and count
    // define which slots are valid, so resetting the data would only cost logic.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + OCC_W'(1);
                2'b01:   count_q <= count_q - OCC_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout      = mem_q[rd_ptr_q];
    assign full      = (count_q == OCC_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign occupancy = count_q;

endmodule

// File: rtl/br_update_unit.sv
// Branch-predictor update/recovery unit.
// Matches in-order resolutions against the oldest in-flight prediction,
// emits registered PHT/PAs/BTB update pulses, and on a mispredict repairs the
// GHR, flushes all in-flight records and blocks new predictions for a while.
module br_update_unit
    import br_update_unit_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = ADDR_WIDTH,
    parameter int GHR_W       = GHR_WIDTH,
    parameter int RECOVER_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    br_update_unit_if.slave  bus
);

    localparam int REC_W = rec_width(ADDR_W, GHR_W);
    localparam int CNT_W = $clog2(RECOVER_CYC + 1);

    upd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             full, empty;
    logic [REC_W-1:0] push_rec, head_rec;
    logic             e_torn;
    logic [ADDR_W-1:0] e_pc, e_tar;
    logic [GHR_W-1:0]  e_ghr;
    logic             pop_en, push_en, mis;

    logic              wr_en_q, wr_en_d;
    logic              wr_data_q, wr_data_d;
    logic              btb_q, btb_d;
    logic              flush_q, flush_d;
    logic [ADDR_W-1:0] up_pc_q, up_pc_d;
    logic [ADDR_W-1:0] up_addr_q, up_addr_d;
    logic [GHR_W-1:0]  re_ghr_q, re_ghr_d;
    logic              res_err_q, res_err_d;

    assign push_rec = {bus.pred_torn, bus.pred_pc, bus.pred_tar, bus.pred_ghr};
    assign {e_torn, e_pc, e_tar, e_ghr} = head_rec;

    // In RECOVER the FIFO is empty, so a resolve can never pop there.
    assign pop_en  = bus.res_valid && !empty;
    assign mis     = pop_en && ((e_torn != bus.res_torn) ||
                                (bus.res_torn && (e_tar != bus.res_tar)));
    // A push into a full FIFO is taken when the oldest entry leaves the same
    // cycle; a push racing a mispredict is wrong-path and dropped.
    assign push_en = bus.pred_valid && (state_q == UPD_NORMAL) &&
                     (!full || pop_en) && !mis;
    assign bus.pred_ready = (state_q == UPD_NORMAL) && !full;

    br_update_unit_upd_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_upd_fifo (
        .clk       (clk),
        .reset     (reset),
        .clr       (mis),
        .push      (push_en),
        .pop       (pop_en),
        .din       (push_rec),
        .dout      (head_rec),
        .full      (full),
        .empty     (empty),
        .occupancy (bus.occupancy)
    );

    // Recovery FSM next state: hold off predictions for RECOVER_CYC cycles.
    // NOTE: every combinational output gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            UPD_NORMAL: begin
                if (mis) begin
                    state_d = UPD_RECOVER;
                    cnt_d   = CNT_W'(RECOVER_CYC);
                end
            end
            UPD_RECOVER: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = UPD_NORMAL;
            end
            default: state_d = UPD_NORMAL;
        endcase
    end

    // Next values of the registered update outputs for the resolving pop.
    always_comb begin
        wr_en_d   = pop_en && bus.res_cond;
        wr_data_d = pop_en && bus.res_cond && bus.res_torn;
        btb_d     = pop_en && bus.res_torn && (!e_torn || (e_tar != bus.res_tar));
        flush_d   = mis;
        up_pc_d   = up_pc_q;
        up_addr_d = up_addr_q;
        re_ghr_d  = re_ghr_q;
        res_err_d = res_err_q || (bus.res_valid && empty);
        if (pop_en) begin
            up_pc_d   = e_pc;
            up_addr_d = (mis && !bus.res_torn) ? e_pc + ADDR_W'(4) : bus.res_tar;
        end
        if (mis) begin
            re_ghr_d = bus.res_cond ? {e_ghr[GHR_W-2:0], bus.res_torn} : e_ghr;
        end
    end

    // State and output registers; reset kills any pulse in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= UPD_NORMAL;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= 1'b0;
            btb_q     <= 1'b0;
            flush_q   <= 1'b0;
            up_pc_q   <= '0;
            up_addr_q <= '0;
            re_ghr_q  <= '0;
            res_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            btb_q     <= btb_d;
            flush_q   <= flush_d;
            up_pc_q   <= up_pc_d;
            up_addr_q <= up_addr_d;
            re_ghr_q  <= re_ghr_d;
            res_err_q <= res_err_d;
        end
    end

    assign bus.gshare_wr_en   = wr_en_q;
    assign bus.PAs_up_en      = wr_en_q;
    assign bus.gshare_wr_data = wr_data_q;
    assign bus.PAs_torn       = wr_data_q;
    assign bus.btb_up_en      = btb_q;
    assign bus.gshare_reen    = flush_q;
    assign bus.flush          = flush_q;
    assign bus.up_pc          = up_pc_q;
    assign bus.up_addr        = up_addr_q;
    assign bus.re_GHR         = re_ghr_q;
    assign bus.res_err        = res_err_q;

endmodule

// File: tb/tb_br_update_unit.sv
// Self-checking bench for br_update_unit: a table of single-branch
// predict/resolve vectors, plus sequences for flush, recovery, full/wrap,
// empty resolves and reset during recovery. Expected responses go into a
// scoreboard queue when a resolve is driven and are popped one cycle later.
module tb_br_update_unit;

    typedef struct {
        logic [31:0] up_pc;
        logic [31:0] up_addr;
        logic [13:0] re_ghr;
        logic        wr_en;
        logic        wr_data;
        logic        btb;
        logic        flush;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptar;
        logic [13:0] pghr;
        logic        rc;
        logic        rt;
        logic [31:0] rtar;
        exp_t        e;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptar;
        logic [13:0] pghr;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    rec_t inflight[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    br_update_unit_if #(.ADDR_W(32), .GHR_W(14), .DEPTH(8)) bus ();

    br_update_unit #(
        .DEPTH       (8),
        .ADDR_W      (32),
        .GHR_W       (14),
        .RECOVER_CYC (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pred_valid = 1'b0;
        bus.res_valid  = 1'b0;
    endtask

    task automatic drive_pred(input logic [31:0] pc, input logic pt,
                              input logic [31:0] ptar, input logic [13:0] pghr);
        bus.pred_valid = 1'b1;
        bus.pred_pc    = pc;
        bus.pred_torn  = pt;
        bus.pred_tar   = ptar;
        bus.pred_ghr   = pghr;
    endtask

    task automatic drive_res(input logic rc, input logic rt, input logic [31:0] rtar);
        bus.res_valid = 1'b1;
        bus.res_cond  = rc;
        bus.res_torn  = rt;
        bus.res_tar   = rtar;
    endtask

    // Reference response for one resolved record.
    function automatic exp_t exp_of(input rec_t r, input logic rc, input logic rt,
                                    input logic [31:0] rtar);
        exp_t e;
        logic m;
        m         = (r.pt != rt) || (rt && (r.ptar != rtar));
        e.up_pc   = r.pc;
        e.wr_en   = rc;
        e.wr_data = rc & rt;
        e.btb     = rt && (!r.pt || (r.ptar != rtar));
        e.flush   = m;
        e.up_addr = (m && !rt) ? r.pc + 32'd4 : rtar;
        e.re_ghr  = rc ? {r.pghr[12:0], rt} : r.pghr;
        return e;
    endfunction

    function automatic vec_t mkv(input string name, input logic [31:0] pc, input logic pt,
                                 input logic [31:0] ptar, input logic [13:0] pghr,
                                 input logic rc, input logic rt, input logic [31:0] rtar,
                                 input logic wr, input logic wd, input logic btb,
                                 input logic fl, input logic [31:0] addr,
                                 input logic [13:0] ghr);
        vec_t v;
        v.name = name; v.pc = pc; v.pt = pt; v.ptar = ptar; v.pghr = pghr;
        v.rc = rc; v.rt = rt; v.rtar = rtar;
        v.e.up_pc = pc; v.e.wr_en = wr; v.e.wr_data = wd; v.e.btb = btb;
        v.e.flush = fl; v.e.up_addr = addr; v.e.re_ghr = ghr;
        return v;
    endfunction

    // Pop the oldest expected response and compare it with the DUT outputs.
    task automatic sb_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_up_pc"},   bus.up_pc,        e.up_pc);
        check({tag, "_up_addr"}, bus.up_addr,      e.up_addr);
        check({tag, "_wr_en"},   bus.gshare_wr_en, e.wr_en);
        check({tag, "_pas_en"},  bus.PAs_up_en,    e.wr_en);
        check({tag, "_btb"},     bus.btb_up_en,    e.btb);
        check({tag, "_flush"},   bus.flush,        e.flush);
        check({tag, "_reen"},    bus.gshare_reen,  e.flush);
        if (e.wr_en) begin
            check({tag, "_wr_data"}, bus.gshare_wr_data, e.wr_data);
            check({tag, "_pas_tn"},  bus.PAs_torn,       e.wr_data);
        end
        if (e.flush) check({tag, "_re_ghr"}, bus.re_GHR, e.re_ghr);
    endtask

    task automatic wait_ready(input int max_cyc);
        for (int i = 0; i < max_cyc && !bus.pred_ready; i++) tick();
        check("ready_wait", bus.pred_ready, 1'b1);
    endtask

    // Push one record, resolve it immediately, and score the response.
    task automatic push_resolve(input string tag, input rec_t r, input logic rc,
                                input logic rt, input logic [31:0] rtar);
        drive_pred(r.pc, r.pt, r.ptar, r.pghr);
        tick();
        idle();
        drive_res(rc, rt, rtar);
        sb_q.push_back(exp_of(r, rc, rt, rtar));
        tick();
        idle();
        sb_check(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rec_t r;
        exp_t e;
        idle();
        bus.pred_pc = '0; bus.pred_torn = 1'b0; bus.pred_tar = '0; bus.pred_ghr = '0;
        bus.res_cond = 1'b0; bus.res_torn = 1'b0; bus.res_tar = '0;

        vecs[0] = mkv("corr_tk_cond", 32'h1000, 1, 32'h2000, 14'h0AAA, 1, 1, 32'h2000,
                      1, 1, 0, 0, 32'h2000, 14'h0);
        vecs[1] = mkv("corr_nt_cond", 32'h1100, 0, 32'h0000, 14'h0001, 1, 0, 32'h5555,
                      1, 0, 0, 0, 32'h5555, 14'h0);
        vecs[2] = mkv("dir_mis_nt_tk", 32'h1000, 0, 32'h0000, 14'h0AAA, 1, 1, 32'h3000,
                      1, 1, 1, 1, 32'h3000, 14'h1555);
        vecs[3] = mkv("dir_mis_tk_nt", 32'h4000, 1, 32'h4800, 14'h3FFF, 1, 0, 32'h9999,
                      1, 0, 0, 1, 32'h4004, 14'h3FFE);
        vecs[4] = mkv("tar_mis_uncond", 32'h1800, 1, 32'h2000, 14'h0123, 0, 1, 32'h2400,
                      0, 0, 1, 1, 32'h2400, 14'h0123);
        vecs[5] = mkv("corr_uncond", 32'h6000, 1, 32'h7000, 14'h0055, 0, 1, 32'h7000,
                      0, 0, 0, 0, 32'h7000, 14'h0);
        vecs[6] = mkv("nt_tar_diff", 32'h6100, 0, 32'h1234, 14'h0002, 1, 0, 32'hABCD,
                      1, 0, 0, 0, 32'hABCD, 14'h0);
        vecs[7] = mkv("jump_unpred", 32'h8000, 0, 32'h0000, 14'h2001, 0, 1, 32'h8800,
                      0, 0, 1, 1, 32'h8800, 14'h2001);

        // Reset state
        #12;
        check("rst_pred_ready", bus.pred_ready,   1'b1);
        check("rst_occupancy",  bus.occupancy,    4'd0);
        check("rst_wr_en",      bus.gshare_wr_en, 1'b0);
        check("rst_btb",        bus.btb_up_en,    1'b0);
        check("rst_flush",      bus.flush,        1'b0);
        check("rst_reen",       bus.gshare_reen,  1'b0);
        check("rst_res_err",    bus.res_err,      1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Push three records, then drain them with correct resolutions
        for (int i = 0; i < 3; i++) begin
            drive_pred(32'hA000 + 32'(i * 4), 1'b1, 32'hB000 + 32'(i * 16), 14'(i));
            tick();
        end
        idle();
        check("push3_occupancy", bus.occupancy, 4'd3);
        for (int i = 0; i < 3; i++) begin
            r = '{32'hA000 + 32'(i * 4), 1'b1, 32'hB000 + 32'(i * 16), 14'(i)};
            drive_res(1'b1, 1'b1, r.ptar);
            sb_q.push_back(exp_of(r, 1'b1, 1'b1, r.ptar));
            tick();
            idle();
            sb_check("drain3");
        end
        check("drain3_occupancy", bus.occupancy, 4'd0);

        // Table of single-branch vectors
        foreach (vecs[i]) begin
            drive_pred(vecs[i].pc, vecs[i].pt, vecs[i].ptar, vecs[i].pghr);
            tick();
            idle();
            drive_res(vecs[i].rc, vecs[i].rt, vecs[i].rtar);
            sb_q.push_back(vecs[i].e);
            tick();
            idle();
            sb_check(vecs[i].name);
            if (vecs[i].e.flush) wait_ready(8);
        end

        // Mispredict with younger entries, plus a push racing the flush
        drive_pred(32'h1000, 1'b0, 32'h0, 14'h0AAA); tick();
        drive_pred(32'h1004, 1'b1, 32'h5000, 14'h0001); tick();
        drive_pred(32'h1008, 1'b1, 32'h5000, 14'h0002); tick();
        idle();
        check("flush_pre_occ", bus.occupancy, 4'd3);
        drive_pred(32'h100C, 1'b1, 32'h5000, 14'h0003);
        drive_res(1'b1, 1'b1, 32'h3000);
        e = '{32'h1000, 32'h3000, 14'h1555, 1'b1, 1'b1, 1'b1, 1'b1};
        sb_q.push_back(e);
        tick();
        idle();
        sb_check("flush_young");
        check("flush_occ",        bus.occupancy,    4'd0);
        check("flush_ready_c0",   bus.pred_ready,   1'b0);
        tick();
        check("flush_ready_c1",   bus.pred_ready,   1'b0);
        check("flush_pulse_end",  bus.flush,        1'b0);
        check("reen_pulse_end",   bus.gshare_reen,  1'b0);
        check("btb_pulse_end",    bus.btb_up_en,    1'b0);
        tick();
        check("flush_ready_c2",   bus.pred_ready,   1'b1);
        check("flush_drop_occ",   bus.occupancy,    4'd0);

        // Fill to DEPTH, then push+resolve in the same cycle across the wrap
        for (int k = 0; k < 8; k++) begin
            r = '{32'hC000 + 32'(k * 4), 1'b1, 32'hD000 + 32'(k * 8), 14'(k)};
            drive_pred(r.pc, r.pt, r.ptar, r.pghr);
            inflight.push_back(r);
            tick();
        end
        idle();
        check("full_ready", bus.pred_ready, 1'b0);
        check("full_occ",   bus.occupancy,  4'd8);
        for (int j = 0; j < 20; j++) begin
            rec_t old;
            r = '{32'hC000 + 32'((8 + j) * 4), 1'b1, 32'hD000 + 32'((8 + j) * 8), 14'(8 + j)};
            old = inflight.pop_front();
            drive_pred(r.pc, r.pt, r.ptar, r.pghr);
            drive_res(1'(j), old.pt, old.ptar);
            sb_q.push_back(exp_of(old, 1'(j), old.pt, old.ptar));
            inflight.push_back(r);
            tick();
            idle();
            sb_check("wrap");
            check("wrap_occ", bus.occupancy, 4'd8);
        end
        while (inflight.size() > 0) begin
            rec_t old;
            old = inflight.pop_front();
            drive_res(1'b1, old.pt, old.ptar);
            sb_q.push_back(exp_of(old, 1'b1, old.pt, old.ptar));
            tick();
            idle();
            sb_check("wrap_drain");
        end
        check("wrap_end_occ",   bus.occupancy,  4'd0);
        check("wrap_end_ready", bus.pred_ready, 1'b1);

        // Resolve with the FIFO empty: no strobes, sticky error
        drive_res(1'b1, 1'b1, 32'h1234);
        tick();
        idle();
        check("empty_wr_en",   bus.gshare_wr_en, 1'b0);
        check("empty_btb",     bus.btb_up_en,    1'b0);
        check("empty_flush",   bus.flush,        1'b0);
        check("empty_res_err", bus.res_err,      1'b1);
        check("empty_occ",     bus.occupancy,    4'd0);
        tick();
        tick();
        check("res_err_sticky", bus.res_err, 1'b1);
        r = '{32'hE000, 1'b1, 32'hE100, 14'h0042};
        push_resolve("after_err", r, 1'b1, 1'b1, 32'hE100);
        check("res_err_kept", bus.res_err, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("res_err_cleared", bus.res_err, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Reset asserted while a flush pulse is live and recovery is pending
        drive_pred(32'h2000, 1'b0, 32'h0, 14'h0011);
        tick();
        idle();
        drive_res(1'b1, 1'b1, 32'h2100);
        tick();
        idle();
        check("mid_rec_flush", bus.flush, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rec_flush_killed", bus.flush,       1'b0);
        check("mid_rec_reen_killed",  bus.gshare_reen, 1'b0);
        check("mid_rec_btb_killed",   bus.btb_up_en,   1'b0);
        check("mid_rec_ready",        bus.pred_ready,  1'b1);
        @(negedge clk);
        reset = 1'b1;
        r = '{32'hF000, 1'b0, 32'h0, 14'h0007};
        push_resolve("post_reset", r, 1'b1, 1'b0, 32'h0);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
